// File: rtl/tx_chk_gen.sv
// tx_chk_gen: self-checking memory traffic generator (write, gap, readback, compare) x NUM_TXN.
// Latency: start -> first wen one cycle later; each transaction takes 2+GAP_CYC+RD_LAT cycles.
// Backpressure: none; the memory must accept every strobe and answer exactly RD_LAT cycles after ren.
// Ports: clk/rst_n (async active-low), start; memory side wen/ren/addr/wdin out, rdout in;
//        status busy/done/pass, err_cnt (saturating), err_addr (first failing address).
module tx_chk_gen #(
  parameter int              DW        = 64,
  parameter int              AW        = 64,
  parameter int              NUM_TXN   = 16,
  parameter int              GAP_CYC   = 4,
  parameter int              RD_LAT    = 1,
  parameter int              PATTERN   = 0,
  parameter logic [AW-1:0]   ADDR_BASE = '0,
  parameter logic [AW-1:0]   ADDR_STEP = AW'(8),
  parameter logic [31:0]     DATA_BASE = 32'h1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          wen,
  output logic          ren,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdin,
  input  logic [DW-1:0] rdout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_WAIT, S_CHK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] inc_q, inc_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          wen_q, wen_d, ren_q, ren_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdin_q, wdin_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [DW-1:0] seed_word, cur_word;
  logic [31:0]   lfsr_nxt;

  // Fibonacci LFSR, taps 32,22,2,1 (bit indices 31,21,1,0), shifting left.
  assign lfsr_nxt  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign seed_word = (PATTERN == 1) ? {(DW/32){DATA_BASE}} : DW'(DATA_BASE);
  assign cur_word  = (PATTERN == 1) ? {(DW/32){lfsr_q}}    : inc_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    inc_d      = inc_q;
    lfsr_d     = lfsr_q;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    addr_d     = addr_q;
    wdin_d     = wdin_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WR;
          idx_d      = '0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          inc_d      = DW'(DATA_BASE);
          lfsr_d     = DATA_BASE;
          wen_d      = 1'b1;
          addr_d     = ADDR_BASE;
          wdin_d     = seed_word;
        end
      end
      S_WR: begin
        // Generator steps once per write; wdin_q keeps the word just written
        // and serves as the expected value for this transaction's compare.
        inc_d  = inc_q + 1'b1;
        lfsr_d = lfsr_nxt;
        if (GAP_CYC > 0) begin
          state_d = S_GAP;
          cnt_d   = 8'(GAP_CYC - 1);
        end else begin
          state_d = S_RD;
          ren_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RD;
          ren_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD: begin
        if (RD_LAT > 1) begin
          state_d = S_WAIT;
          cnt_d   = 8'(RD_LAT - 2);
        end else begin
          state_d = S_CHK;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_CHK;
        else               cnt_d   = cnt_q - 1'b1;
      end
      S_CHK: begin
        if (rdout != wdin_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d  = err_cnt_q + 1'b1;
          if (err_cnt_q == 16'd0)    err_addr_d = addr_q;
        end
        if (idx_q == 16'(NUM_TXN - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WR;
          idx_d   = idx_q + 1'b1;
          wen_d   = 1'b1;
          addr_d  = addr_q + ADDR_STEP;
          wdin_d  = cur_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pass_d = (state_d == S_DONE) && (err_cnt_d == 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      inc_q      <= DW'(DATA_BASE);
      lfsr_q     <= DATA_BASE;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      addr_q     <= '0;
      wdin_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      inc_q      <= inc_d;
      lfsr_q     <= lfsr_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      addr_q     <= addr_d;
      wdin_q     <= wdin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wen      = wen_q;
  assign ren      = ren_q;
  assign addr     = addr_q;
  assign wdin     = wdin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_tx_chk_gen.sv
// tb_tx_chk_gen: directed checks of tx_chk_gen across four parameter sets.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_tx_chk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic rst_a, rst_b;
  logic start0, start1, start2, start3;
  logic corrupt;
  int   lat_mode;

  // ---------------- u0: defaults, 1-cycle memory with optional corruption
  logic        wen0, ren0, busy0, done0, pass0;
  logic [63:0] addr0, wdin0, rdout0, err_addr0;
  logic [15:0] err0;
  logic [63:0] mem0 [0:127];
  tx_chk_gen u0 (.clk(clk), .rst_n(rst_a), .start(start0), .wen(wen0), .ren(ren0),
    .addr(addr0), .wdin(wdin0), .rdout(rdout0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .err_addr(err_addr0));
  always @(posedge clk) begin
    if (wen0) mem0[addr0[9:3]] <= wdin0;
    if (ren0) rdout0 <= mem0[addr0[9:3]] ^
      {63'd0, corrupt && (addr0 == 64'h18 || addr0 == 64'h40)};
  end

  // ---------------- u1: GAP_CYC=0, RD_LAT=3, memory latency 2 or 3 (data valid one cycle only)
  logic        wen1, ren1, busy1, done1, pass1;
  logic [63:0] addr1, wdin1, rdout1, err_addr1;
  logic [15:0] err1;
  logic [63:0] mem1 [0:127];
  logic [2:0]  v1;
  logic [63:0] d1_s1, d1_s2, d1_s3;
  tx_chk_gen #(.GAP_CYC(0), .RD_LAT(3)) u1 (.clk(clk), .rst_n(rst_b), .start(start1),
    .wen(wen1), .ren(ren1), .addr(addr1), .wdin(wdin1), .rdout(rdout1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .err_addr(err_addr1));
  always @(posedge clk) begin
    if (wen1) mem1[addr1[9:3]] <= wdin1;
    v1    <= {v1[1:0], ren1};
    d1_s1 <= mem1[addr1[9:3]];
    d1_s2 <= d1_s1;
    d1_s3 <= d1_s2;
  end
  assign rdout1 = (lat_mode == 2) ? (v1[1] ? d1_s2 : 64'hDEAD_BEEF_DEAD_BEEF)
                                  : (v1[2] ? d1_s3 : 64'hDEAD_BEEF_DEAD_BEEF);

  // ---------------- u2: AW=8, address wrap
  logic        wen2, ren2, busy2, done2, pass2;
  logic [7:0]  addr2, err_addr2;
  logic [63:0] wdin2, rdout2;
  logic [15:0] err2;
  logic [63:0] mem2 [0:31];
  tx_chk_gen #(.AW(8), .ADDR_BASE(8'hF0), .ADDR_STEP(8'd8)) u2 (.clk(clk), .rst_n(rst_b),
    .start(start2), .wen(wen2), .ren(ren2), .addr(addr2), .wdin(wdin2), .rdout(rdout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .err_addr(err_addr2));
  always @(posedge clk) begin
    if (wen2) mem2[addr2[7:3]] <= wdin2;
    if (ren2) rdout2 <= mem2[addr2[7:3]];
  end

  // ---------------- u3: PATTERN=1 (LFSR), seed 1
  logic        wen3, ren3, busy3, done3, pass3;
  logic [63:0] addr3, wdin3, rdout3, err_addr3;
  logic [15:0] err3;
  logic [63:0] mem3 [0:127];
  tx_chk_gen #(.PATTERN(1), .DATA_BASE(32'h1)) u3 (.clk(clk), .rst_n(rst_b), .start(start3),
    .wen(wen3), .ren(ren3), .addr(addr3), .wdin(wdin3), .rdout(rdout3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(err3), .err_addr(err_addr3));
  always @(posedge clk) begin
    if (wen3) mem3[addr3[9:3]] <= wdin3;
    if (ren3) rdout3 <= mem3[addr3[9:3]];
  end

  // ---------------- monitors
  int both_cnt   = 0;  // wen and ren high together on any instance
  int strobes0   = 0;  // u0 strobes, zeroed by the reset test
  int lfsr_bad   = 0;
  int lfsr_wr    = 0;
  logic [7:0] wr2_addr [0:3];
  int wr2_n      = 0;
  always @(posedge clk) begin
    if ((wen0 && ren0) || (wen1 && ren1) || (wen2 && ren2) || (wen3 && ren3)) both_cnt++;
    if (wen0 || ren0) strobes0++;
    if (wen3) begin
      lfsr_wr++;
      if (wdin3[63:32] != wdin3[31:0] || wdin3[31:0] == 32'd0) lfsr_bad++;
    end
    if (wen2 && wr2_n < 4) begin
      wr2_addr[wr2_n] = addr2;
      wr2_n++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller in the middle of cycle 1 (first WR) with start low.
  task automatic kick0();
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    start0 = 0; start1 = 0; start2 = 0; start3 = 0;
    corrupt = 1'b0; lat_mode = 3;
    step(3);
    n_chk++; if ({wen0, ren0, busy0, done0, pass0} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {wen0, ren0, busy0, done0, pass0}); else n_pass++;
    n_chk++; if ({addr0, wdin0, err_addr0, err0} !== '0) $display("FAIL reset_buses got addr=%h wdin=%h ea=%h ec=%h exp 0", addr0, wdin0, err_addr0, err0); else n_pass++;
    n_chk++; if ({wen3, busy3, done3, wdin3} !== '0) $display("FAIL reset_u3 got wen=%b busy=%b done=%b wdin=%h exp 0", wen3, busy3, done3, wdin3); else n_pass++;
    rst_a = 1'b1; rst_b = 1'b1;
    step(3);
    n_chk++; if ({wen0, ren0, busy0, done0} !== 4'b0) $display("FAIL idle_no_strobe got %b exp 0000", {wen0, ren0, busy0, done0}); else n_pass++;
  endtask

  task automatic test_basic();
    kick0();                                            // cycle 1
    n_chk++; if ({wen0, ren0, busy0} !== 3'b101) $display("FAIL basic_c1_strobes got %b exp 101", {wen0, ren0, busy0}); else n_pass++;
    n_chk++; if (addr0 !== 64'h0 || wdin0 !== 64'h1000) $display("FAIL basic_c1_data got addr=%h wdin=%h exp 0/1000", addr0, wdin0); else n_pass++;
    step(2);                                            // cycle 3, GAP
    n_chk++; if ({wen0, ren0} !== 2'b00) $display("FAIL basic_gap got %b exp 00", {wen0, ren0}); else n_pass++;
    step(3);                                            // cycle 6
    n_chk++; if ({wen0, ren0} !== 2'b01 || addr0 !== 64'h0) $display("FAIL basic_c6_ren got wen/ren=%b addr=%h exp 01/0", {wen0, ren0}, addr0); else n_pass++;
    step(2);                                            // cycle 8
    n_chk++; if (wen0 !== 1'b1 || addr0 !== 64'h8 || wdin0 !== 64'h1001) $display("FAIL basic_c8_wr got wen=%b addr=%h wdin=%h exp 1/8/1001", wen0, addr0, wdin0); else n_pass++;
    step(104);                                          // cycle 112
    n_chk++; if (done0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL basic_c112 got done=%b busy=%b exp 0/1", done0, busy0); else n_pass++;
    step(1);                                            // cycle 113
    n_chk++; if ({done0, pass0, busy0} !== 3'b110 || err0 !== 16'd0) $display("FAIL basic_c113 got done/pass/busy=%b err=%0d exp 110/0", {done0, pass0, busy0}, err0); else n_pass++;
    step(5);
    n_chk++; if (done0 !== 1'b1 || pass0 !== 1'b1) $display("FAIL basic_done_held got done=%b pass=%b exp 1/1", done0, pass0); else n_pass++;
  endtask

  task automatic test_errors();
    corrupt = 1'b1;
    kick0();
    n_chk++; if (done0 !== 1'b0 || pass0 !== 1'b0) $display("FAIL err_start_clears got done=%b pass=%b exp 0/0", done0, pass0); else n_pass++;
    for (int i = 0; i < 300 && done0 !== 1'b1; i++) step(1);
    n_chk++; if (done0 !== 1'b1) $display("FAIL err_done_timeout got done=%b exp 1", done0); else n_pass++;
    n_chk++; if (err0 !== 16'd2 || err_addr0 !== 64'h18 || pass0 !== 1'b0) $display("FAIL err_counts got cnt=%0d addr=%h pass=%b exp 2/18/0", err0, err_addr0, pass0); else n_pass++;
    corrupt = 1'b0;
  endtask

  task automatic test_start_busy();
    kick0();                                            // cycle 1
    step(1); start0 = 1'b1; step(1); start0 = 1'b0;     // pulse during cycle 2
    step(5);                                            // cycle 8
    n_chk++; if (wen0 !== 1'b1 || addr0 !== 64'h8 || err0 !== 16'd0) $display("FAIL busy_start_c8 got wen=%b addr=%h err=%0d exp 1/8/0", wen0, addr0, err0); else n_pass++;
    step(42); start0 = 1'b1; step(1); start0 = 1'b0;    // pulse during cycle 50
    step(61);                                           // cycle 112
    n_chk++; if (done0 !== 1'b0) $display("FAIL busy_start_c112 got done=%b exp 0", done0); else n_pass++;
    step(1);
    n_chk++; if (done0 !== 1'b1 || pass0 !== 1'b1) $display("FAIL busy_start_c113 got done=%b pass=%b exp 1/1", done0, pass0); else n_pass++;
  endtask

  task automatic test_hold_start();
    start0 = 1'b1;
    step(1);                                            // cycle 1
    n_chk++; if (wen0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0) $display("FAIL hold_c1 got wen=%b done=%b pass=%b exp 1/0/0", wen0, done0, pass0); else n_pass++;
    step(112);                                          // cycle 113
    n_chk++; if (done0 !== 1'b1) $display("FAIL hold_c113 got done=%b exp 1", done0); else n_pass++;
    step(1);                                            // cycle 114: restarted
    n_chk++; if (wen0 !== 1'b1 || done0 !== 1'b0 || addr0 !== 64'h0 || busy0 !== 1'b1) $display("FAIL hold_restart got wen=%b done=%b addr=%h busy=%b exp 1/0/0/1", wen0, done0, addr0, busy0); else n_pass++;
    start0 = 1'b0;
    for (int i = 0; i < 300 && done0 !== 1'b1; i++) step(1);
    n_chk++; if (done0 !== 1'b1 || pass0 !== 1'b1) $display("FAIL hold_second_run got done=%b pass=%b exp 1/1", done0, pass0); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    kick0();                                            // cycle 1
    step(23);                                           // cycle 24: GAP of txn idx 3
    n_chk++; if (busy0 !== 1'b1 || addr0 !== 64'h18) $display("FAIL midrun_pre got busy=%b addr=%h exp 1/18", busy0, addr0); else n_pass++;
    rst_a = 1'b0;
    #1;
    n_chk++; if ({busy0, wen0, ren0, done0, pass0} !== 5'b0 || addr0 !== 64'h0 || wdin0 !== 64'h0) $display("FAIL midrun_async got flags=%b addr=%h wdin=%h exp 0", {busy0, wen0, ren0, done0, pass0}, addr0, wdin0); else n_pass++;
    step(1);
    rst_a = 1'b1;
    strobes0 = 0;
    step(40);
    n_chk++; if (strobes0 !== 0 || busy0 !== 1'b0) $display("FAIL midrun_quiet got strobes=%0d busy=%b exp 0/0", strobes0, busy0); else n_pass++;
    kick0();
    n_chk++; if (wen0 !== 1'b1 || addr0 !== 64'h0 || wdin0 !== 64'h1000) $display("FAIL midrun_restart got wen=%b addr=%h wdin=%h exp 1/0/1000", wen0, addr0, wdin0); else n_pass++;
    for (int i = 0; i < 300 && done0 !== 1'b1; i++) step(1);
    n_chk++; if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 16'd0) $display("FAIL midrun_rerun got done=%b pass=%b err=%0d exp 1/1/0", done0, pass0, err0); else n_pass++;
  endtask

  task automatic test_rdlat();
    lat_mode = 2;
    start1 = 1'b1; step(1); start1 = 1'b0;              // cycle 1
    n_chk++; if ({wen1, ren1} !== 2'b10) $display("FAIL rdlat_c1 got %b exp 10", {wen1, ren1}); else n_pass++;
    step(1);
    n_chk++; if ({wen1, ren1} !== 2'b01 || addr1 !== 64'h0) $display("FAIL rdlat_c2 got %b addr=%h exp 01/0", {wen1, ren1}, addr1); else n_pass++;
    for (int i = 0; i < 300 && done1 !== 1'b1; i++) step(1);
    n_chk++; if (done1 !== 1'b1 || err1 !== 16'd16 || pass1 !== 1'b0 || err_addr1 !== 64'h0) $display("FAIL rdlat_lat2 got done=%b err=%0d pass=%b ea=%h exp 1/16/0/0", done1, err1, pass1, err_addr1); else n_pass++;
    lat_mode = 3;
    start1 = 1'b1; step(1); start1 = 1'b0;
    for (int i = 0; i < 300 && done1 !== 1'b1; i++) step(1);
    n_chk++; if (done1 !== 1'b1 || err1 !== 16'd0 || pass1 !== 1'b1) $display("FAIL rdlat_lat3 got done=%b err=%0d pass=%b exp 1/0/1", done1, err1, pass1); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    start2 = 1'b1; step(1); start2 = 1'b0;
    for (int i = 0; i < 300 && done2 !== 1'b1; i++) step(1);
    n_chk++; if (wr2_addr[0] !== 8'hF0 || wr2_addr[1] !== 8'hF8) $display("FAIL wrap_first got %h %h exp F0 F8", wr2_addr[0], wr2_addr[1]); else n_pass++;
    n_chk++; if (wr2_addr[2] !== 8'h00 || wr2_addr[3] !== 8'h08) $display("FAIL wrap_after got %h %h exp 00 08", wr2_addr[2], wr2_addr[3]); else n_pass++;
    n_chk++; if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 16'd0) $display("FAIL wrap_result got done=%b pass=%b err=%0d exp 1/1/0", done2, pass2, err2); else n_pass++;
  endtask

  task automatic test_lfsr();
    start3 = 1'b1; step(1); start3 = 1'b0;
    n_chk++; if (wen3 !== 1'b1 || wdin3 !== 64'h00000001_00000001) $display("FAIL lfsr_seed got wen=%b wdin=%h exp 1/0000000100000001", wen3, wdin3); else n_pass++;
    for (int i = 0; i < 300 && done3 !== 1'b1; i++) step(1);
    n_chk++; if (lfsr_wr !== 16 || lfsr_bad !== 0) $display("FAIL lfsr_words got writes=%0d bad=%0d exp 16/0", lfsr_wr, lfsr_bad); else n_pass++;
    n_chk++; if (done3 !== 1'b1 || pass3 !== 1'b1 || err3 !== 16'd0) $display("FAIL lfsr_result got done=%b pass=%b err=%0d exp 1/1/0", done3, pass3, err3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_start_busy();
    test_hold_start();
    test_reset_midrun();
    test_rdlat();
    test_addr_wrap();
    test_lfsr();
    n_chk++; if (both_cnt !== 0) $display("FAIL wen_ren_exclusive got %0d overlaps exp 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_chk_gen.md
Name: tx_chk_gen

Overview:
- Parametrised successor of the single-shot write/read stimulus generator: a self-checking memory traffic generator.
- On `start` it issues NUM_TXN write-then-readback transactions over a simple wen/ren/addr/wdin/rdout memory port.
- Each readback is compared with the data written; mismatches are counted and the first failing address is captured.
- Sits between a memory model or DUT-side RAM and the testbench/system controller.

Parameters:
- DW, 64, data width (multiple of 32, ≥32)
- AW, 64, address width (≥8)
- NUM_TXN, 16, transactions per run (1..65535)
- GAP_CYC, 4, idle cycles between the write cycle and its readback (0..255)
- RD_LAT, 1, cycles from the `ren` cycle to valid `rdout` (1..15)
- PATTERN, 0, data mode: 0 = incrementing, 1 = LFSR
- ADDR_BASE, 0, first address
- ADDR_STEP, 8, address increment per transaction
- DATA_BASE, 32'h1000, first data word (PATTERN=0) or LFSR seed (PATTERN=1; must be nonzero)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- wen  out  1  one-cycle write strobe
- ren  out  1  one-cycle read strobe
- addr  out  AW  address for wen/ren
- wdin  out  DW  write data
- rdout  in  DW  read data, valid RD_LAT cycles after ren
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- pass  out  1  done & (err_cnt==0)
- err_cnt  out  16  mismatch count, saturating
- err_addr  out  AW  address of the first mismatch; 0 if none

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; transaction index 0; LFSR loaded with DATA_BASE.
  - Reset mid-run aborts immediately; no further strobes until a new start.
- All outputs are registered.
- FSM states: IDLE, WR, GAP, RD, WAIT, CHK, DONE.
- IDLE/DONE:
  - start=1 at edge T → WR in the cycle after T.
  - On that start: clear err_cnt, err_addr and done; reset index and data generator; busy=1.
- WR (1 cycle):
  - wen=1; addr=ADDR_BASE+idx*ADDR_STEP, modulo 2^AW (wraps silently).
  - wdin=current pattern word.
  - The expected word is latched internally.
  - Next state: GAP if GAP_CYC>0, else RD.
- GAP: GAP_CYC cycles with wen=ren=0, then RD.
- RD (1 cycle):
  - ren=1; addr is the same as in WR.
  - If the ren cycle is c, rdout is sampled at the end of cycle c+RD_LAT.
  - WAIT covers RD_LAT-1 cycles; CHK is the sampling cycle.
- CHK:
  - If rdout≠expected: err_cnt+=1, saturating at 16'hFFFF; if this is the first mismatch, err_addr=addr.
  - If idx==NUM_TXN-1 → DONE, with done=1 and busy=0 in the next cycle; else idx+=1 → WR.
- Transaction period = 2+GAP_CYC+RD_LAT cycles.
- Pattern generation, advanced once per WR:
  - PATTERN=0: word = DATA_BASE+idx, zero-extended to DW, modulo 2^DW.
  - PATTERN=1: 32-bit Fibonacci LFSR, taps 32,22,2,1; shifts once after each WR; wdin = the 32-bit value replicated DW/32 times.
- wen and ren are never high in the same cycle.
- addr and wdin hold their last values outside WR/RD.
- start while busy is ignored.
- start held high in DONE restarts a run each time DONE is reached.
- rdout is ignored outside CHK.
- pass is 0 whenever done=0.

Test Plan:
- Defaults, memory model with 1-cycle read latency, pulse start at cycle 0:
  - wen at cycle 1 with addr=0, wdin=64'h1000; ren at cycle 6 with addr=0.
  - Second wen at cycle 8 with addr=8, wdin=64'h1001.
  - done=1 at cycle 113; pass=1; err_cnt=0.
- Memory model corrupts bit 0 on addresses 0x18 and 0x40 → err_cnt=2, err_addr=0x18, pass=0.
- GAP_CYC=0, RD_LAT=3:
  - ren immediately follows wen.
  - Compare uses rdout from exactly 3 cycles after ren; a model returning data at latency 2 gives all mismatches, err_cnt=16.
- AW=8, ADDR_BASE=8'hF0, ADDR_STEP=8: addresses F0, F8, 00, 08… (wrap); no errors with a correct model.
- Assert rst_n=0 for one cycle during GAP of txn 3:
  - Outputs go to 0 asynchronously; busy=0; no wen/ren afterwards.
  - A new start runs cleanly from addr=ADDR_BASE.
- start pulses while busy have no effect.
- PATTERN=1, DATA_BASE=1, DW=64: wdin upper and lower halves are equal and nonzero on every write; readback passes.
